reg_file_scan_rd: RTL

Read-side sequencer for the single-write-port register file. Takes the register file's flattened read bus, snapshots it on request, and streams the entries out one word per transfer over a valid/ready handshake, either as a full scan or as a single addressed read. Sits between the register file and a debug/readback or bus-response path, so consumers never tap the wide bus directly.

---
 rtl/reg_file_scan_rd_if.sv | 11 +
 rtl/reg_file_scan_rd.sv | 58 +++++
 2 files changed

// File: rtl/reg_file_scan_rd_if.sv
// reg_file_scan_rd_if: valid/ready read stream carrying one register entry per transfer
interface reg_file_scan_rd_if #(parameter int DATA_W = 16, parameter int ADDR_W = 1);
  logic rd_valid;
  logic rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic rd_last;
  logic rd_err;
  modport master (output rd_valid, rd_data, rd_addr, rd_last, rd_err, input rd_ready);
  modport slave (input rd_valid, rd_data, rd_addr, rd_last, rd_err, output rd_ready);
endinterface

// File: rtl/reg_file_scan_rd.sv
// reg_file_scan_rd: snapshots the flattened register bus and streams entries as a scan or single read
module reg_file_scan_rd #(
  parameter int DATA_W = 16,
  parameter int NUM_REGS = 2,
  parameter int ADDR_W = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic [DATA_W*NUM_REGS-1:0] a_in,
  input  logic start,
  input  logic single,
  input  logic [ADDR_W-1:0] addr_in,
  reg_file_scan_rd_if.master rd,
  output logic busy,
  output logic done
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] NR = (ADDR_W + 1)'(NUM_REGS);
  state_t state, state_n;
  logic [DATA_W-1:0] snap [NUM_REGS];
  logic single_q;
  logic [ADDR_W-1:0] addr_q, idx, cur;
  logic err, last, fire;
  always_comb begin
    cur = single_q ? addr_q : idx;
    err = single_q && ({1'b0, addr_q} >= NR);
    last = single_q || idx == LAST;
    busy = state == STREAM;
    fire = busy && rd.rd_ready;
    rd.rd_valid = busy;
    rd.rd_addr = busy ? cur : '0;
    rd.rd_err = busy && err;
    rd.rd_last = busy && last;
    rd.rd_data = busy && !err ? snap[cur] : '0;
    state_n = busy ? (fire && last ? IDLE : STREAM) : (start ? STREAM : IDLE);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // Entry 0 lives in the most significant slice of a_in
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) snap[i] <= '0;
      single_q <= 1'b0;
      addr_q <= '0;
      idx <= '0;
      done <= 1'b0;
    end else begin
      done <= fire && last;
      if (!busy && start) begin
        for (int i = 0; i < NUM_REGS; i++) snap[i] <= a_in[DATA_W*(NUM_REGS-1-i) +: DATA_W];
        single_q <= single;
        addr_q <= addr_in;
        idx <= '0;
      end else if (fire && !last) idx <= idx + 1'b1;
    end
endmodule
